// File: rtl/fxp_avg_addsub_if.sv
`default_nettype none
// ============================================================================
//  Module   : fxp_avg_addsub_if
//  Purpose  : Operand-side and result-side handshake bundle for the
//             averaging add/sub producer stage.
//  Revision : 1.0  initial release
// ============================================================================
interface fxp_avg_addsub_if #(
    parameter int DATA_WIDTH = 64,
    parameter int LANES_MAX  = DATA_WIDTH / 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] vs2;
    logic [DATA_WIDTH-1:0] vs1;
    logic [1:0]            sew;
    logic                  is_signed;
    logic                  is_sub;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] avg_out;
    logic [LANES_MAX-1:0]  rbit_out;
    logic [1:0]            sew_out;

    // Producer of operand beats / consumer of results
    modport master (
        output in_valid, vs2, vs1, sew, is_signed, is_sub, out_ready,
        input  in_ready, out_valid, avg_out, rbit_out, sew_out
    );

    // The averaging stage itself
    modport slave (
        input  in_valid, vs2, vs1, sew, is_signed, is_sub, out_ready,
        output in_ready, out_valid, avg_out, rbit_out, sew_out
    );
endinterface
`default_nettype wire

// File: rtl/fxp_avg_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : fxp_avg_addsub
//  Purpose  : Two-stage valid/ready pipeline producing, per element lane, the
//             halved (w+1)-bit sum/difference and the shifted-out LSB that
//             the rounding stage uses to apply vxrm.
//  Revision : 1.0  initial release
// ============================================================================
module fxp_avg_addsub #(
    parameter int DATA_WIDTH = 64,
    parameter int LANES_MAX  = DATA_WIDTH / 8
) (
    input  wire logic          clk,
    input  wire logic          rst,      // asynchronous, active-low
    fxp_avg_addsub_if.slave    bus
);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_vs2;
    logic [DATA_WIDTH-1:0] s1_vs1;
    logic [1:0]            s1_sew;
    logic                  s1_signed;
    logic                  s1_sub;
    logic                  s2_advance;
    logic                  s1_advance;

    assign s2_advance   = !bus.out_valid || bus.out_ready;
    assign s1_advance   = !s1_valid || s2_advance;
    assign bus.in_ready = s1_advance;

    // S1 occupancy; cleared asynchronously so in-flight beats are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
        end else if (s1_advance) begin
            s1_valid <= bus.in_valid;
        end
    end

    // S1 operand/control capture on every accepted beat (no reset needed)
    always_ff @(posedge clk) begin
        if (s1_advance && bus.in_valid) begin
            s1_vs2    <= bus.vs2;
            s1_vs1    <= bus.vs1;
            s1_sew    <= bus.sew;
            s1_signed <= bus.is_signed;
            s1_sub    <= bus.is_sub;
        end
    end

    // ------------------------------------------------------------------
    // Per-width lane arithmetic. All four element widths are computed in
    // parallel and the one matching the beat's sew is selected; keeping
    // each width in its own lane array guarantees carries never cross
    // lane boundaries.
    // ------------------------------------------------------------------
    genvar k, l, j;
    for (k = 0; k < 4; k++) begin : g_sew
        localparam int W = 8 << k;
        localparam int N = DATA_WIDTH / W;

        logic [DATA_WIDTH-1:0] avg;
        logic [N-1:0]          rb;
        logic [LANES_MAX-1:0]  rb_spread;

        for (l = 0; l < N; l++) begin : g_lane
            logic [W:0] a;
            logic [W:0] b;
            logic [W:0] r;
            // One extra bit makes the sum/difference exact for both signednesses
            assign a = {s1_signed & s1_vs2[l*W + W - 1], s1_vs2[l*W +: W]};
            assign b = {s1_signed & s1_vs1[l*W + W - 1], s1_vs1[l*W +: W]};
            assign r = s1_sub ? (a - b) : (a + b);
            assign avg[l*W +: W] = r[W:1];
            assign rb[l]         = r[0];
        end

        // Round bit sits at the byte index of the lane's least-significant byte
        for (j = 0; j < LANES_MAX; j++) begin : g_spread
            if ((j % (1 << k)) == 0) begin : g_rb
                assign rb_spread[j] = rb[j >> k];
            end else begin : g_zero
                assign rb_spread[j] = 1'b0;
            end
        end
    end

    logic [DATA_WIDTH-1:0] avg_next;
    logic [LANES_MAX-1:0]  rbit_next;

    // Select the result for the element width carried by the S1 beat
    always_comb begin
        avg_next  = g_sew[0].avg;
        rbit_next = g_sew[0].rb_spread;
        case (s1_sew)
            2'd1: begin
                avg_next  = g_sew[1].avg;
                rbit_next = g_sew[1].rb_spread;
            end
            2'd2: begin
                avg_next  = g_sew[2].avg;
                rbit_next = g_sew[2].rb_spread;
            end
            2'd3: begin
                avg_next  = g_sew[3].avg;
                rbit_next = g_sew[3].rb_spread;
            end
            default: ;
        endcase
    end

    // S2 output register; holds stable while downstream stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid <= 1'b0;
            bus.avg_out   <= '0;
            bus.rbit_out  <= '0;
            bus.sew_out   <= 2'd0;
        end else if (s2_advance) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.avg_out  <= avg_next;
                bus.rbit_out <= rbit_next;
                bus.sew_out  <= s1_sew;
            end
        end
    end

endmodule
`default_nettype wire
